mem_exec_unit: RTL and testbench
================================

MEM_EXEC_UNIT -- requirements
Module: mem_exec_unit

Interface
REQ-001 Parameter NUM_PHYS_REGS, default 64; physical register count, PREG_BITS = clog2(NUM_PHYS_REGS).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 issue_valid  input  1  issue slot carries a memory op this cycle.
REQ-005 issue_prd  input  PREG_BITS  destination physical register.
REQ-006 issue_addr  input  32  effective address (base + offset, precomputed).
REQ-007 issue_data  input  32  store data.
REQ-008 issue_mem_write / issue_mem_read  input  1 each  store / load.
REQ-009 issue_rob_idx  input  7  ROB tag.
REQ-010 mem_available  output  1  unit accepts an issue this cycle.
REQ-011 dmem_req, dmem_we  output  1 each  data-memory request, write enable.
REQ-012 dmem_addr, dmem_wdata  output  32 each  word address, store data.
REQ-013 dmem_ack  input  1; dmem_rdata  input  32  request complete, load data valid with ack.
REQ-014 wb_valid  output  1; wb_ready  input  1  writeback handshake.
REQ-015 wb_prd  output  PREG_BITS; wb_data  output  32; wb_reg_write  output  1; wb_rob_idx  output  7; wb_exc  output  1  misaligned-address fault.
REQ-016 flush  input  1  squash all in-flight work.

Function
REQ-017 FSM states IDLE, REQ, WB; one operation in flight at most.
REQ-018 mem_available SHALL equal (state==IDLE && !flush), combinationally.
REQ-019 Accept: in IDLE with issue_valid && mem_available && (mem_read||mem_write), latch prd, addr, data, rob_idx, op type; issue_valid while unavailable SHALL be ignored.
REQ-020 Both read and write set: treated as store.
REQ-021 Aligned accept (addr[1:0]==0): next state REQ; misaligned: next state WB with wb_exc=1, wb_reg_write=0, wb_data=0, no dmem request ever issued.
REQ-022 In REQ: dmem_req=1, dmem_we=latched store, dmem_addr/dmem_wdata from latches, held stable until dmem_ack; dmem_ack sampled in the same cycle as dmem_req counts.
REQ-023 On ack (not squashed): load latches wb_data=dmem_rdata, wb_reg_write=1; store latches wb_data=0, wb_reg_write=0; next state WB.
REQ-024 Minimum latency: issue cycle N, dmem_req at N+1, ack at N+1 -> wb_valid at N+2.
REQ-025 In WB: wb_valid=1, all wb_* held stable until wb_valid && wb_ready; then next state IDLE (mem_available=1 the following cycle, no same-cycle turnaround).
REQ-026 Outputs dmem_req and wb_valid SHALL be 0 outside REQ and WB respectively; other wb_*/dmem_* values are don't-care when their valid is 0.
REQ-027 Flush in IDLE: issue ignored that cycle.
REQ-028 Flush in REQ: set squash flag; dmem_req held until ack (bus handshake never abandoned); on ack discard result, go IDLE, clear squash; no wb_valid.
REQ-029 Flush in WB: go IDLE next cycle, wb_valid deasserted; flush coinciding with wb_ready still counts as flushed (ROB discards).
REQ-030 Flush while squash already set: no additional effect.

Reset
REQ-031 rst asserted: immediately state=IDLE, squash=0, dmem_req=0, wb_valid=0, wb_exc=0, all latches 0; mem_available=1 once flush=0.
REQ-032 Reset mid-REQ abandons the request; memory side is reset together.

Verification
REQ-033 Load: issue addr=0x100, prd=5, rob=3; ack next cycle with rdata=0xDEADBEEF -> wb_valid at N+2, wb_data=0xDEADBEEF, wb_prd=5, wb_rob_idx=3, wb_reg_write=1.
REQ-034 Store: issue addr=0x200, data=0x12345678; ack delayed 3 cycles -> dmem_req/we/addr/wdata stable 4 cycles, then wb_valid, wb_reg_write=0, mem_available=0 throughout.
REQ-035 Backpressure: wb_ready=0 for 5 cycles -> wb_* stable, second issue_valid ignored; wb_ready=1 -> IDLE, mem_available=1 next cycle.
REQ-036 Flush in REQ: flush 1 cycle, ack 2 cycles later -> dmem_req held until ack, no wb_valid, mem_available=1 cycle after ack.
REQ-037 Misaligned: load addr=0x102 -> no dmem_req, wb_valid next cycle with wb_exc=1, wb_reg_write=0.
REQ-038 Async reset asserted mid-WB (between clock edges) -> wb_valid=0 and dmem_req=0 immediately, mem_available=1.

Source files
------------

// File: rtl/mem_exec_unit.sv
// ---------------------------------------------------------------------------
// mem_exec_unit
//   Single-entry load/store execution unit. It accepts one memory op from the
//   issue slot, performs a single data-memory handshake, and returns the
//   result over a writeback handshake. At most one op is in flight.
//   Misaligned (addr[1:0] != 0) ops skip the memory and write back a fault.
//
// Ports
//   clk, rst             clock, async active-high reset
//   i_issue_*            issue slot: valid, dest preg, addr, store data,
//                        read/write flags, ROB tag
//   o_mem_available      unit can take an issue this cycle
//   o_dmem_* / i_dmem_*  data-memory request (req/we/addr/wdata), ack+rdata
//   o_wb_* / i_wb_ready  writeback: valid, preg, data, reg_write, rob, exc
//   i_flush              squash everything in flight
// ---------------------------------------------------------------------------
module mem_exec_unit #(
   parameter  int NUM_PHYS_REGS = 64,
   localparam int PREG_BITS     = $clog2(NUM_PHYS_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_issue_valid,
   input  logic [PREG_BITS-1:0] i_issue_prd,
   input  logic [31:0]          i_issue_addr,
   input  logic [31:0]          i_issue_data,
   input  logic                 i_issue_mem_write,
   input  logic                 i_issue_mem_read,
   input  logic [6:0]           i_issue_rob_idx,
   output logic                 o_mem_available,
   output logic                 o_dmem_req,
   output logic                 o_dmem_we,
   output logic [31:0]          o_dmem_addr,
   output logic [31:0]          o_dmem_wdata,
   input  logic                 i_dmem_ack,
   input  logic [31:0]          i_dmem_rdata,
   output logic                 o_wb_valid,
   input  logic                 i_wb_ready,
   output logic [PREG_BITS-1:0] o_wb_prd,
   output logic [31:0]          o_wb_data,
   output logic                 o_wb_reg_write,
   output logic [6:0]           o_wb_rob_idx,
   output logic                 o_wb_exc,
   input  logic                 i_flush
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_squash;
   logic                 r_is_store;
   logic [PREG_BITS-1:0] r_prd;
   logic [31:0]          r_addr;
   logic [31:0]          r_wdata;
   logic [6:0]           r_rob_idx;
   logic                 r_dmem_req;
   logic                 r_wb_valid;
   logic [31:0]          r_wb_data;
   logic                 r_wb_reg_write;
   logic                 r_wb_exc;

   logic                 w_accept;
   logic                 w_aligned;
   logic                 w_discard;

   assign o_mem_available = (r_state == S_IDLE) && !i_flush;
   assign w_accept  = o_mem_available && i_issue_valid &&
                      (i_issue_mem_read || i_issue_mem_write);
   assign w_aligned = (i_issue_addr[1:0] == 2'b00);
   // A flush arriving in the same cycle as the ack squashes that ack too.
   assign w_discard = r_squash || i_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_squash       <= 1'b0;
         r_is_store     <= 1'b0;
         r_prd          <= '0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_rob_idx      <= '0;
         r_dmem_req     <= 1'b0;
         r_wb_valid     <= 1'b0;
         r_wb_data      <= '0;
         r_wb_reg_write <= 1'b0;
         r_wb_exc       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_prd      <= i_issue_prd;
                  r_addr     <= i_issue_addr;
                  r_wdata    <= i_issue_data;
                  r_rob_idx  <= i_issue_rob_idx;
                  // read+write together behaves as a store
                  r_is_store <= i_issue_mem_write;
                  if (w_aligned) begin
                     r_state    <= S_REQ;
                     r_dmem_req <= 1'b1;
                  end else begin
                     // fault goes straight to writeback, memory untouched
                     r_state        <= S_WB;
                     r_wb_valid     <= 1'b1;
                     r_wb_exc       <= 1'b1;
                     r_wb_reg_write <= 1'b0;
                     r_wb_data      <= '0;
                  end
               end
            end
            S_REQ: begin
               // the bus handshake is always completed, even when squashed
               if (i_flush)
                  r_squash <= 1'b1;
               if (i_dmem_ack) begin
                  r_dmem_req <= 1'b0;
                  r_squash   <= 1'b0;
                  if (w_discard) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state        <= S_WB;
                     r_wb_valid     <= 1'b1;
                     r_wb_exc       <= 1'b0;
                     r_wb_reg_write <= !r_is_store;
                     r_wb_data      <= r_is_store ? 32'd0 : i_dmem_rdata;
                  end
               end
            end
            S_WB: begin
               // flush wins over a simultaneous wb_ready; the ROB drops it
               if (i_flush || i_wb_ready) begin
                  r_state    <= S_IDLE;
                  r_wb_valid <= 1'b0;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_dmem_req <= 1'b0;
               r_wb_valid <= 1'b0;
               r_squash   <= 1'b0;
            end
         endcase
      end
   end

   assign o_dmem_req     = r_dmem_req;
   assign o_dmem_we      = r_is_store;
   assign o_dmem_addr    = r_addr;
   assign o_dmem_wdata   = r_wdata;
   assign o_wb_valid     = r_wb_valid;
   assign o_wb_prd       = r_prd;
   assign o_wb_data      = r_wb_data;
   assign o_wb_reg_write = r_wb_reg_write;
   assign o_wb_rob_idx   = r_rob_idx;
   assign o_wb_exc       = r_wb_exc;

endmodule

// File: tb/tb_mem_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_exec_unit
//   Directed scenarios followed by randomized transactions. Each transaction
//   is described at op level (kind, address, data, memory latency, writeback
//   stall, flush point); the expected bus and writeback behaviour per cycle
//   is derived from that description.
// ---------------------------------------------------------------------------
module tb_mem_exec_unit;
   localparam int PB = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_issue_valid;
   logic [PB-1:0] i_issue_prd;
   logic [31:0]   i_issue_addr;
   logic [31:0]   i_issue_data;
   logic          i_issue_mem_write;
   logic          i_issue_mem_read;
   logic [6:0]    i_issue_rob_idx;
   logic          o_mem_available;
   logic          o_dmem_req;
   logic          o_dmem_we;
   logic [31:0]   o_dmem_addr;
   logic [31:0]   o_dmem_wdata;
   logic          i_dmem_ack;
   logic [31:0]   i_dmem_rdata;
   logic          o_wb_valid;
   logic          i_wb_ready;
   logic [PB-1:0] o_wb_prd;
   logic [31:0]   o_wb_data;
   logic          o_wb_reg_write;
   logic [6:0]    o_wb_rob_idx;
   logic          o_wb_exc;
   logic          i_flush;

   int n_tests = 0;
   int n_fail  = 0;

   mem_exec_unit #(.NUM_PHYS_REGS(64)) dut (
      .clk(clk), .rst(rst),
      .i_issue_valid(i_issue_valid), .i_issue_prd(i_issue_prd),
      .i_issue_addr(i_issue_addr), .i_issue_data(i_issue_data),
      .i_issue_mem_write(i_issue_mem_write), .i_issue_mem_read(i_issue_mem_read),
      .i_issue_rob_idx(i_issue_rob_idx), .o_mem_available(o_mem_available),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
      .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
      .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
      .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
      .o_wb_prd(o_wb_prd), .o_wb_data(o_wb_data),
      .o_wb_reg_write(o_wb_reg_write), .o_wb_rob_idx(o_wb_rob_idx),
      .o_wb_exc(o_wb_exc), .i_flush(i_flush)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      i_issue_valid     = 1'b0;
      i_issue_prd       = '0;
      i_issue_addr      = '0;
      i_issue_data      = '0;
      i_issue_mem_write = 1'b0;
      i_issue_mem_read  = 1'b0;
      i_issue_rob_idx   = '0;
      i_dmem_ack        = 1'b0;
      i_dmem_rdata      = '0;
      i_wb_ready        = 1'b0;
      i_flush           = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_avail"}, o_mem_available, 1'b1);
      chk({tag, "_req"},   o_dmem_req,      1'b0);
      chk({tag, "_wbv"},   o_wb_valid,      1'b0);
   endtask

   // One complete transaction.
   //   fl: 0 = no flush, 1 = flush in first memory cycle, 2 = flush in first WB cycle
   task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata,
                        input logic [PB-1:0] prd, input logic [6:0] rob,
                        input int ack_dly, input int rdy_dly, input int fl,
                        input string tag);
      bit           aligned;
      bit           store;
      logic [31:0]  exp_data;
      logic [31:0]  junk;
      aligned = (addr % 4) == 0;
      store   = wr;
      cyc();
      i_issue_valid     = 1'b1;
      i_issue_mem_read  = rd;
      i_issue_mem_write = wr;
      i_issue_addr      = addr;
      i_issue_data      = data;
      i_issue_prd       = prd;
      i_issue_rob_idx   = rob;
      @(negedge clk);
      chk_idle({tag, "_issue"});
      cyc();
      quiet_inputs();
      if (!(rd || wr)) begin
         @(negedge clk);
         chk_idle({tag, "_noop"});
         return;
      end
      if (aligned) begin
         for (int i = 0; i <= ack_dly; i++) begin
            i_flush      = (fl == 1) && (i == 0);
            i_dmem_ack   = (i == ack_dly);
            junk         = $urandom;
            i_dmem_rdata = (i == ack_dly) ? rdata : junk;
            @(negedge clk);
            chk({tag, "_req"},   o_dmem_req,      1'b1);
            chk({tag, "_we"},    o_dmem_we,       store);
            chk({tag, "_addr"},  o_dmem_addr,     addr);
            chk({tag, "_wdata"}, o_dmem_wdata,    data);
            chk({tag, "_rav"},   o_mem_available, 1'b0);
            chk({tag, "_rwbv"},  o_wb_valid,      1'b0);
            cyc();
         end
         quiet_inputs();
         if (fl == 1) begin
            @(negedge clk);
            chk_idle({tag, "_sq"});
            return;
         end
      end
      exp_data = (aligned && !store) ? rdata : 32'd0;
      for (int j = 0; j <= rdy_dly; j++) begin
         i_wb_ready = (j == rdy_dly);
         if (fl == 2) begin
            i_flush    = 1'b1;
            i_wb_ready = $urandom_range(0, 1) == 1;
         end
         // an issue attempt during writeback must be ignored
         i_issue_valid    = 1'b1;
         i_issue_mem_read = 1'b1;
         i_issue_addr     = 32'h0000_0400;
         i_issue_prd      = prd + 1;
         @(negedge clk);
         chk({tag, "_wbv"},  o_wb_valid,      1'b1);
         chk({tag, "_prd"},  o_wb_prd,        prd);
         chk({tag, "_data"}, o_wb_data,       exp_data);
         chk({tag, "_rw"},   o_wb_reg_write,  aligned && !store);
         chk({tag, "_rob"},  o_wb_rob_idx,    rob);
         chk({tag, "_exc"},  o_wb_exc,        !aligned);
         chk({tag, "_wav"},  o_mem_available, 1'b0);
         chk({tag, "_wreq"}, o_dmem_req,      1'b0);
         cyc();
         if (fl == 2) break;
      end
      quiet_inputs();
      @(negedge clk);
      chk_idle({tag, "_done"});
   endtask

   initial begin
      quiet_inputs();
      rst = 1'b1;
      #2;
      chk_idle("reset");
      chk("reset_exc", o_wb_exc, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // load, ack immediately: wb two cycles after issue
      do_op(1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 6'd5, 7'd3, 0, 0, 0, "load");
      // store, ack after 3 extra cycles
      do_op(0, 1, 32'h200, 32'h12345678, 32'hAAAA5555, 6'd9, 7'd10, 3, 0, 0, "store");
      // writeback stall for 5 cycles
      do_op(1, 0, 32'h300, 32'h0, 32'h0BADF00D, 6'd7, 7'd99, 1, 5, 0, "bp");
      // flush in memory phase, ack 2 cycles later
      do_op(1, 0, 32'h104, 32'h0, 32'h11112222, 6'd1, 7'd4, 2, 0, 1, "flreq");
      // misaligned load faults without memory access
      do_op(1, 0, 32'h102, 32'h0, 32'h0, 6'd2, 7'd8, 0, 0, 0, "misal");
      // read+write together is a store
      do_op(1, 1, 32'h208, 32'hCAFE0001, 32'h77777777, 6'd3, 7'd5, 1, 1, 0, "rw");
      // flush during writeback
      do_op(0, 1, 32'h20C, 32'h55, 32'h0, 6'd4, 7'd6, 0, 2, 2, "flwb");
      // issue with neither read nor write is ignored
      do_op(0, 0, 32'h0, 32'h0, 32'h0, 6'd0, 7'd0, 0, 0, 0, "noop");

      // issue during flush in IDLE is ignored
      cyc();
      i_flush = 1'b1; i_issue_valid = 1'b1; i_issue_mem_read = 1'b1;
      @(negedge clk);
      chk("flidle_avail", o_mem_available, 1'b0);
      cyc();
      quiet_inputs();
      @(negedge clk);
      chk_idle("flidle_after");

      // async reset mid-WB
      cyc();
      i_issue_valid = 1'b1; i_issue_mem_read = 1'b1; i_issue_addr = 32'h102;
      cyc();
      quiet_inputs();
      @(negedge clk);
      chk("rstwb_pre", o_wb_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk_idle("rstwb");
      chk("rstwb_exc", o_wb_exc, 1'b0);
      #1 rst = 1'b0;

      // async reset mid-REQ
      cyc();
      i_issue_valid = 1'b1; i_issue_mem_write = 1'b1; i_issue_addr = 32'h40;
      cyc();
      quiet_inputs();
      @(negedge clk);
      chk("rstreq_pre", o_dmem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk_idle("rstreq");
      #1 rst = 1'b0;

      // randomized transactions
      for (int k = 0; k < 60; k++) begin
         logic [31:0] a, d, r, sel;
         int          fl;
         bit          rd, wr;
         sel = $urandom_range(0, 9);
         rd  = (sel < 4) || (sel == 9);
         wr  = (sel >= 4 && sel < 8) || (sel == 9);
         a   = $urandom;
         a   = (a & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
         d   = $urandom;
         r   = $urandom;
         fl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
         do_op(rd, wr, a, d, r, PB'($urandom), 7'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), fl, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
